// File: rtl/seq_divider_16bit.sv
// seq_divider_16bit: restoring unsigned divider, one quotient bit per clock,
// with a start/busy/done handshake and a single-cycle divide-by-zero path.
module seq_divider_16bit #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {IDLE, RUN, DZ} state_t;
    state_t state, state_n;
    logic [WIDTH-1:0] dvd, dvd_n, dsr, dsr_n, rem, rem_n, q_n, r_n, rem_sh;
    logic [WIDTH:0] diff;
    logic [CW-1:0] cnt, cnt_n;
    logic done_n, dz_n, ge;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            dvd         <= '0;
            dsr         <= '0;
            rem         <= '0;
            cnt         <= '0;
            Q           <= '0;
            R           <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            state       <= state_n;
            dvd         <= dvd_n;
            dsr         <= dsr_n;
            rem         <= rem_n;
            cnt         <= cnt_n;
            Q           <= q_n;
            R           <= r_n;
            done        <= done_n;
            div_by_zero <= dz_n;
        end
    end
    // dvd holds the unconsumed dividend bits on top and the quotient bits shifted in below
    always_comb begin
        rem_sh  = {rem[WIDTH-2:0], dvd[WIDTH-1]};
        diff    = {1'b0, rem_sh} - {1'b0, dsr};
        ge      = !diff[WIDTH];
        state_n = state;
        dvd_n   = dvd;
        dsr_n   = dsr;
        rem_n   = rem;
        cnt_n   = cnt;
        q_n     = Q;
        r_n     = R;
        done_n  = 1'b0;
        dz_n    = div_by_zero;
        case (state)
            IDLE: if (start) begin
                dvd_n   = A;
                dsr_n   = B;
                rem_n   = '0;
                cnt_n   = '0;
                dz_n    = 1'b0;
                state_n = (B == '0) ? DZ : RUN;
            end
            RUN: begin
                dvd_n = {dvd[WIDTH-2:0], ge};
                rem_n = ge ? diff[WIDTH-1:0] : rem_sh;
                cnt_n = cnt + 1'b1;
                if (cnt == CW'(WIDTH - 1)) begin
                    q_n     = dvd_n;
                    r_n     = rem_n;
                    done_n  = 1'b1;
                    state_n = IDLE;
                end
            end
            DZ: begin
                q_n     = '1;
                r_n     = dvd;
                dz_n    = 1'b1;
                done_n  = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end
    assign busy = (state != IDLE);
endmodule

// File: tb/tb_seq_divider_16bit.sv
// tb_seq_divider_16bit: directed and random checks of the sequential divider;
// inputs change and outputs are sampled on the falling clock edge.
module tb_seq_divider_16bit;
    logic clk = 0, rst = 1, start = 0;
    logic [15:0] A = 0, B = 0;
    logic [15:0] Q, R;
    logic busy, done, div_by_zero;
    int compared = 0, mismatched = 0, done_cnt = 0;

    seq_divider_16bit dut (
        .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
        .Q(Q), .R(R), .busy(busy), .done(done), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (done && busy) begin
            mismatched++;
            $display("FAIL done_with_busy: done=%0b busy=%0b required not both high", done, busy);
        end
    end

    // caller is at a falling edge; returns at the falling edge after the accepting edge
    task automatic do_start(input logic [15:0] a, input logic [15:0] b);
        start = 1; A = a; B = b;
        @(negedge clk);
        start = 0;
    endtask

    task automatic wait_done(output int cyc, output bit ok);
        ok = 0;
        for (cyc = 0; cyc < 40; cyc++) begin
            if (done) begin ok = 1; break; end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        compared += 5;
        if (Q !== 16'd0) begin mismatched++; $display("FAIL reset_Q: got %0d want 0", Q); end
        if (R !== 16'd0) begin mismatched++; $display("FAIL reset_R: got %0d want 0", R); end
        if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy: got %0b want 0", busy); end
        if (done !== 1'b0) begin mismatched++; $display("FAIL reset_done: got %0b want 0", done); end
        if (div_by_zero !== 1'b0) begin mismatched++; $display("FAIL reset_dz: got %0b want 0", div_by_zero); end
    endtask

    task automatic test_basic;
        int cyc; bit ok;
        do_start(16'd100, 16'd7);
        compared++;
        if (busy !== 1'b1) begin mismatched++; $display("FAIL basic_busy: got %0b want 1", busy); end
        wait_done(cyc, ok);
        compared += 6;
        if (!ok || cyc != 16) begin mismatched++; $display("FAIL basic_latency: got %0d (ok=%0b) want 16", cyc, ok); end
        if (Q !== 16'd14) begin mismatched++; $display("FAIL basic_Q: got %0d want 14", Q); end
        if (R !== 16'd2) begin mismatched++; $display("FAIL basic_R: got %0d want 2", R); end
        if (div_by_zero !== 1'b0) begin mismatched++; $display("FAIL basic_dz: got %0b want 0", div_by_zero); end
        if (busy !== 1'b0) begin mismatched++; $display("FAIL basic_busy_done: got %0b want 0", busy); end
        @(negedge clk);
        if (done !== 1'b0) begin mismatched++; $display("FAIL basic_done_pulse: got %0b want 0", done); end
    endtask

    task automatic test_extremes;
        int cyc; bit ok;
        do_start(16'hFFFF, 16'd1);
        wait_done(cyc, ok);
        compared += 3;
        if (!ok || cyc != 16) begin mismatched++; $display("FAIL ext1_latency: got %0d want 16", cyc); end
        if (Q !== 16'hFFFF) begin mismatched++; $display("FAIL ext1_Q: got %h want ffff", Q); end
        if (R !== 16'd0) begin mismatched++; $display("FAIL ext1_R: got %0d want 0", R); end
        do_start(16'd3, 16'd10);
        wait_done(cyc, ok);
        compared += 3;
        if (!ok || cyc != 16) begin mismatched++; $display("FAIL ext2_latency: got %0d want 16", cyc); end
        if (Q !== 16'd0) begin mismatched++; $display("FAIL ext2_Q: got %0d want 0", Q); end
        if (R !== 16'd3) begin mismatched++; $display("FAIL ext2_R: got %0d want 3", R); end
    endtask

    task automatic test_div_zero;
        int cyc; bit ok;
        do_start(16'd5, 16'd0);
        wait_done(cyc, ok);
        compared += 4;
        if (!ok || cyc != 1) begin mismatched++; $display("FAIL dz_latency: got %0d want 1", cyc); end
        if (div_by_zero !== 1'b1) begin mismatched++; $display("FAIL dz_flag: got %0b want 1", div_by_zero); end
        if (Q !== 16'hFFFF) begin mismatched++; $display("FAIL dz_Q: got %h want ffff", Q); end
        if (R !== 16'd5) begin mismatched++; $display("FAIL dz_R: got %0d want 5", R); end
        @(negedge clk);
        do_start(16'd9, 16'd3);
        compared += 3;
        if (div_by_zero !== 1'b0) begin mismatched++; $display("FAIL dz_clear: got %0b want 0", div_by_zero); end
        if (Q !== 16'hFFFF) begin mismatched++; $display("FAIL dz_hold_Q: got %h want ffff", Q); end
        if (R !== 16'd5) begin mismatched++; $display("FAIL dz_hold_R: got %0d want 5", R); end
        wait_done(cyc, ok);
        compared += 3;
        if (!ok || cyc != 16) begin mismatched++; $display("FAIL dz_next_latency: got %0d want 16", cyc); end
        if (Q !== 16'd3) begin mismatched++; $display("FAIL dz_next_Q: got %0d want 3", Q); end
        if (R !== 16'd0) begin mismatched++; $display("FAIL dz_next_R: got %0d want 0", R); end
    endtask

    task automatic test_back_to_back;
        int cyc; bit ok;
        do_start(16'd100, 16'd7);
        repeat (3) @(negedge clk);
        do_start(16'd50, 16'd5);
        wait_done(cyc, ok);
        compared += 3;
        if (!ok || cyc != 12) begin mismatched++; $display("FAIL ignore_latency: got %0d want 12", cyc); end
        if (Q !== 16'd14) begin mismatched++; $display("FAIL ignore_Q: got %0d want 14", Q); end
        if (R !== 16'd2) begin mismatched++; $display("FAIL ignore_R: got %0d want 2", R); end
        do_start(16'd50, 16'd5);
        compared++;
        if (busy !== 1'b1) begin mismatched++; $display("FAIL b2b_accept: busy got %0b want 1", busy); end
        wait_done(cyc, ok);
        compared += 3;
        if (!ok || cyc != 16) begin mismatched++; $display("FAIL b2b_latency: got %0d want 16", cyc); end
        if (Q !== 16'd10) begin mismatched++; $display("FAIL b2b_Q: got %0d want 10", Q); end
        if (R !== 16'd0) begin mismatched++; $display("FAIL b2b_R: got %0d want 0", R); end
    endtask

    task automatic test_async_reset;
        int cyc; bit ok;
        @(negedge clk);
        do_start(16'd1000, 16'd3);
        repeat (7) @(negedge clk);
        #2 rst = 1;
        #1;
        compared += 4;
        if (busy !== 1'b0) begin mismatched++; $display("FAIL arst_busy: got %0b want 0", busy); end
        if (done !== 1'b0) begin mismatched++; $display("FAIL arst_done: got %0b want 0", done); end
        if (Q !== 16'd0) begin mismatched++; $display("FAIL arst_Q: got %0d want 0", Q); end
        if (R !== 16'd0) begin mismatched++; $display("FAIL arst_R: got %0d want 0", R); end
        @(negedge clk);
        #1 rst = 0;
        @(negedge clk);
        do_start(16'd1000, 16'd3);
        wait_done(cyc, ok);
        compared += 3;
        if (!ok || cyc != 16) begin mismatched++; $display("FAIL arst_latency: got %0d want 16", cyc); end
        if (Q !== 16'd333) begin mismatched++; $display("FAIL arst_Q2: got %0d want 333", Q); end
        if (R !== 16'd1) begin mismatched++; $display("FAIL arst_R2: got %0d want 1", R); end
    endtask

    task automatic test_random;
        int cyc, base; bit ok;
        logic [15:0] a, b;
        @(negedge clk);
        base = done_cnt;
        for (int i = 0; i < 1000; i++) begin
            a = 16'($urandom_range(0, 65535));
            b = (i % 3 == 0) ? 16'($urandom_range(1, 255)) : 16'($urandom_range(1, 65535));
            do_start(a, b);
            wait_done(cyc, ok);
            compared += 2;
            if (!ok || ({16'd0, Q} * {16'd0, b} + {16'd0, R}) !== {16'd0, a}) begin
                mismatched++;
                $display("FAIL rand_identity: %0d/%0d got Q=%0d R=%0d ok=%0b", a, b, Q, R, ok);
            end
            if (!(R < b)) begin mismatched++; $display("FAIL rand_rem: %0d/%0d got R=%0d want < %0d", a, b, R, b); end
        end
        @(negedge clk);
        compared++;
        if (done_cnt - base != 1000) begin mismatched++; $display("FAIL rand_done_count: got %0d want 1000", done_cnt - base); end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst = 0;
        @(negedge clk);
        test_reset;
        test_basic;
        test_extremes;
        test_div_zero;
        test_back_to_back;
        test_async_reset;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
